// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and FSM state type for the pipeline hazard controller.
package hazard_pkg;

    localparam int OP_W_DEF = 5;

    localparam logic [4:0] RTYPE   = 5'b00000;
    localparam logic [4:0] LW      = 5'b01000;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// With HAZARD_STALL_CNT_EN defined, the stall/bubble counter outputs are included.
interface hazard_ctrl_if #(
    parameter int OP_W = 5
`ifdef HAZARD_STALL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
);
    logic [OP_W-1:0] dOpcode;
    logic [OP_W-1:0] dRs;
    logic [OP_W-1:0] dRt;
    logic            dUsesRt;
    logic [OP_W-1:0] xOpcode;
    logic [OP_W-1:0] xAluop;
    logic [OP_W-1:0] xRd;
    logic            xBranchTaken;
    logic            mdReady;

    logic            pcEnable;
    logic            fdEnable;
    logic            dxEnable;
    logic            xmEnable;
    logic            dxNop;
    logic            flush;
    logic            mdStart;
    logic            mdBusy;
`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] bubbleCount;
`endif

    modport master (
        output dOpcode, dRs, dRt, dUsesRt, xOpcode, xAluop, xRd, xBranchTaken, mdReady,
        input  pcEnable, fdEnable, dxEnable, xmEnable, dxNop, flush, mdStart, mdBusy
`ifdef HAZARD_STALL_CNT_EN
        ,
        input  stallCycles, bubbleCount
`endif
    );

    modport slave (
        input  dOpcode, dRs, dRt, dUsesRt, xOpcode, xAluop, xRd, xBranchTaken, mdReady,
        output pcEnable, fdEnable, dxEnable, xmEnable, dxNop, flush, mdStart, mdBusy
`ifdef HAZARD_STALL_CNT_EN
        ,
        output stallCycles, bubbleCount
`endif
    );

endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// Multiply/divide handshake sequencer: RUN -> MD_WAIT -> MD_DONE -> RUN,
// with a registered one-cycle start pulse and a busy flag.
module md_seq
    import hazard_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      i_is_md,
    input  logic      i_md_ready,
    output md_state_t o_state,
    output logic      o_md_start,
    output logic      o_md_busy
);

    md_state_t r_state;
    md_state_t w_state_next;
    logic      r_md_start;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_md_start <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_md_start <= (r_state == RUN) && i_is_md;
        end
    end

    // A ready pulse arriving in the first MD_WAIT cycle is already accepted.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            RUN:     if (i_is_md) w_state_next = MD_WAIT;
            MD_WAIT: if (i_md_ready) w_state_next = MD_DONE;
            MD_DONE: w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    assign o_state    = r_state;
    assign o_md_start = r_md_start;
    assign o_md_busy  = (r_state == MD_WAIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush, mul/div freeze.
// Define HAZARD_STALL_CNT_EN to add saturating stall/bubble counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int OP_W = 5
`ifdef HAZARD_STALL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
)(
    input  logic          clock,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    localparam logic [OP_W-1:0] ZERO_REG = '0;

    md_state_t w_state;
    logic      w_is_md;
    logic      w_load_use;
    logic      w_md_start;
    logic      w_md_busy;
    logic      w_pc_en;
    logic      w_fd_en;
    logic      w_dx_en;
    logic      w_xm_en;
    logic      w_dx_nop;
    logic      r_flush;

    assign w_is_md = (bus.xOpcode == RTYPE) &&
                     ((bus.xAluop == ALU_MUL) || (bus.xAluop == ALU_DIV));

    assign w_load_use = (bus.xOpcode == LW) && (bus.xRd != ZERO_REG) &&
                        ((bus.xRd == bus.dRs) || (bus.dUsesRt && (bus.xRd == bus.dRt)));

    md_seq u_md_seq (
        .clock      (clock),
        .reset      (reset),
        .i_is_md    (w_is_md),
        .i_md_ready (bus.mdReady),
        .o_state    (w_state),
        .o_md_start (w_md_start),
        .o_md_busy  (w_md_busy)
    );

    // Branch redirect overrides load-use; mul/div overrides both.
    always_comb begin
        w_pc_en  = 1'b1;
        w_fd_en  = 1'b1;
        w_dx_en  = 1'b1;
        w_xm_en  = 1'b1;
        w_dx_nop = 1'b0;
        unique case (w_state)
            RUN: begin
                if (w_is_md) begin
                    w_pc_en = 1'b0;
                    w_fd_en = 1'b0;
                    w_dx_en = 1'b0;
                    w_xm_en = 1'b0;
                end else if (!bus.xBranchTaken && w_load_use) begin
                    w_pc_en  = 1'b0;
                    w_fd_en  = 1'b0;
                    w_dx_nop = 1'b1;
                end
            end
            MD_WAIT: begin
                w_pc_en = 1'b0;
                w_fd_en = 1'b0;
                w_dx_en = 1'b0;
                w_xm_en = 1'b0;
            end
            default: ;
        endcase
    end

    // Flush drives asynchronous latch resets, so it must come straight from a flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_flush <= 1'b0;
        end else begin
            r_flush <= (w_state == RUN) && bus.xBranchTaken && !w_is_md;
        end
    end

    assign bus.pcEnable = w_pc_en;
    assign bus.fdEnable = w_fd_en;
    assign bus.dxEnable = w_dx_en;
    assign bus.xmEnable = w_xm_en;
    assign bus.dxNop    = w_dx_nop;
    assign bus.flush    = r_flush;
    assign bus.mdStart  = w_md_start;
    assign bus.mdBusy   = w_md_busy;

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_bubble_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_bubble_count <= '0;
        end else begin
            if (!w_pc_en && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if ((w_dx_nop || r_flush) && (r_bubble_count != {CNT_W{1'b1}}))
                r_bubble_count <= r_bubble_count + 1'b1;
        end
    end

    assign bus.stallCycles = r_stall_cycles;
    assign bus.bubbleCount = r_bubble_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic,
// expectations from a cycle-level behavioural model of the pipeline rules.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic pc;
        logic fd;
        logic dx;
        logic xm;
        logic nop;
        logic flush;
        logic start;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    // Model of the pipeline controller: a mul/div either is not in flight,
    // is waiting for its result, or has just produced it this cycle.
    bit md_waiting      = 0;
    bit md_result_cycle = 0;
    bit flush_due       = 0;
    bit start_due       = 0;

    function automatic bit ref_is_md(input logic [4:0] op, input logic [4:0] alu);
        return (op == 5'd0) && (alu == 5'd6 || alu == 5'd7);
    endfunction

    function automatic bit ref_load_use(input logic [4:0] xop, input logic [4:0] xrd,
                                        input logic [4:0] drs, input logic [4:0] drt,
                                        input logic uses);
        if (xop != 5'd8 || xrd == 5'd0) return 0;
        return (xrd == drs) || (uses && xrd == drt);
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_inputs(input logic [4:0] dop, input logic [4:0] drs, input logic [4:0] drt,
                              input logic uses, input logic [4:0] xop, input logic [4:0] xalu,
                              input logic [4:0] xrd, input logic br, input logic rdy);
        bus.dOpcode      = dop;
        bus.dRs          = drs;
        bus.dRt          = drt;
        bus.dUsesRt      = uses;
        bus.xOpcode      = xop;
        bus.xAluop       = xalu;
        bus.xRd          = xrd;
        bus.xBranchTaken = br;
        bus.mdReady      = rdy;
    endtask

    // One pipeline cycle: apply inputs after the edge, queue the expected response.
    task automatic cyc(input logic [4:0] dop, input logic [4:0] drs, input logic [4:0] drt,
                       input logic uses, input logic [4:0] xop, input logic [4:0] xalu,
                       input logic [4:0] xrd, input logic br, input logic rdy);
        exp_t e;
        bit   md, lu, freeze, bubble;
        @(posedge clock);
        #1;
        set_inputs(dop, drs, drt, uses, xop, xalu, xrd, br, rdy);
        md     = ref_is_md(xop, xalu);
        lu     = ref_load_use(xop, xrd, drs, drt, uses);
        freeze = md_waiting || (!md_result_cycle && md);
        bubble = !freeze && !md_result_cycle && !br && lu;
        e.pc    = !(freeze || bubble);
        e.fd    = !(freeze || bubble);
        e.dx    = !freeze;
        e.xm    = !freeze;
        e.nop   = bubble;
        e.flush = flush_due;
        e.start = start_due;
        e.busy  = md_waiting;
        exp_q.push_back(e);
        if (md_result_cycle) begin
            md_result_cycle = 0;
            start_due       = 0;
            flush_due       = 0;
        end else if (md_waiting) begin
            start_due = 0;
            flush_due = 0;
            if (rdy) begin
                md_waiting      = 0;
                md_result_cycle = 1;
            end
        end else begin
            start_due  = md;
            md_waiting = md;
            flush_due  = br && !md;
        end
    endtask

    task automatic nop_cyc(input logic rdy);
        cyc(5'd0, 5'd1, 5'd2, 1'b1, 5'd4, 5'd0, 5'd9, 1'b0, rdy);
    endtask

    // Monitor: compares every queued expectation against the DUT mid-cycle.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d: pc=%b fd=%b dx=%b xm=%b nop=%b flush=%b start=%b busy=%b",
                     n_txn, bus.pcEnable, bus.fdEnable, bus.dxEnable, bus.xmEnable,
                     bus.dxNop, bus.flush, bus.mdStart, bus.mdBusy);
            chk("pcEnable", bus.pcEnable, e.pc);
            chk("fdEnable", bus.fdEnable, e.fd);
            chk("dxEnable", bus.dxEnable, e.dx);
            chk("xmEnable", bus.xmEnable, e.xm);
            chk("dxNop",    bus.dxNop,    e.nop);
            chk("flush",    bus.flush,    e.flush);
            chk("mdStart",  bus.mdStart,  e.start);
            chk("mdBusy",   bus.mdBusy,   e.busy);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] xop, xalu;
        set_inputs(5'd0, 5'd0, 5'd0, 1'b0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("reset_flush",   bus.flush,    1'b0);
        chk("reset_mdStart", bus.mdStart,  1'b0);
        chk("reset_mdBusy",  bus.mdBusy,   1'b0);
        chk("reset_pcEn",    bus.pcEnable, 1'b1);
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;

        // Load-use on rs, then hazard clears.
        cyc(5'd0, 5'd3, 5'd7, 1'b1, LW, 5'd0, 5'd3, 1'b0, 1'b0);
        nop_cyc(1'b0);
        // Register zero never stalls.
        cyc(5'd0, 5'd0, 5'd0, 1'b1, LW, 5'd0, 5'd0, 1'b0, 1'b0);
        // rt match only counts when rt is read.
        cyc(5'd0, 5'd1, 5'd5, 1'b0, LW, 5'd0, 5'd5, 1'b0, 1'b0);
        cyc(5'd0, 5'd1, 5'd5, 1'b1, LW, 5'd0, 5'd5, 1'b0, 1'b0);
        nop_cyc(1'b0);
        // Branch with simultaneous load-use: no bubble, flush next cycle only.
        repeat (3) nop_cyc(1'b0);
        cyc(5'd0, 5'd6, 5'd7, 1'b1, LW, 5'd0, 5'd6, 1'b1, 1'b0);
        nop_cyc(1'b0);
        nop_cyc(1'b0);

        // Multiply: detect, 5 wait cycles (ready on the 5th), one done cycle.
        cyc(5'd0, 5'd1, 5'd2, 1'b1, RTYPE, ALU_MUL, 5'd4, 1'b0, 1'b0);
        repeat (4) cyc(5'd0, 5'd1, 5'd2, 1'b1, RTYPE, ALU_MUL, 5'd4, 1'b0, 1'b0);
        cyc(5'd0, 5'd1, 5'd2, 1'b1, RTYPE, ALU_MUL, 5'd4, 1'b0, 1'b1);
        cyc(5'd0, 5'd1, 5'd2, 1'b1, RTYPE, ALU_MUL, 5'd4, 1'b0, 1'b0);
        repeat (3) nop_cyc(1'b0);
        // Divide with ready in the very first wait cycle.
        cyc(5'd0, 5'd1, 5'd2, 1'b1, RTYPE, ALU_DIV, 5'd4, 1'b1, 1'b0);
        cyc(5'd0, 5'd1, 5'd2, 1'b1, RTYPE, ALU_DIV, 5'd4, 1'b0, 1'b1);
        cyc(5'd0, 5'd1, 5'd2, 1'b1, RTYPE, ALU_DIV, 5'd4, 1'b0, 1'b0);
        nop_cyc(1'b0);

        // Asynchronous reset while waiting on a multiply.
        cyc(5'd0, 5'd1, 5'd2, 1'b1, RTYPE, ALU_MUL, 5'd4, 1'b0, 1'b0);
        cyc(5'd0, 5'd1, 5'd2, 1'b1, RTYPE, ALU_MUL, 5'd4, 1'b0, 1'b0);
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_mdBusy",  bus.mdBusy,   1'b0);
        chk("async_rst_mdStart", bus.mdStart,  1'b0);
        chk("async_rst_pcEn",    bus.pcEnable, 1'b0);
        set_inputs(5'd0, 5'd1, 5'd2, 1'b1, 5'd4, 5'd0, 5'd9, 1'b0, 1'b0);
        #1;
        chk("async_rst_pcEn_run", bus.pcEnable, 1'b1);
        @(negedge clock);
        #1 reset = 1'b0;
        md_waiting = 0; md_result_cycle = 0; flush_due = 0; start_due = 0;
        nop_cyc(1'b1);
        nop_cyc(1'b1);
        nop_cyc(1'b0);

        // Random traffic with frequent register collisions.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    xop = LW;
                2:       xop = RTYPE;
                3:       xop = 5'd4;
                default: xop = 5'(($urandom_range(0, 31)));
            endcase
            xalu = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? ALU_MUL : ALU_DIV)
                                               : 5'($urandom_range(0, 5));
            cyc(5'($urandom_range(0, 31)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), xop, xalu, 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0));
        end

        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the write-enable, bubble and flush inputs of the PC register, the F/D latch, the D/X latch and the X/M latch.
- Detects three conditions:
  - load-use hazards between the D/X latch and the decode stage;
  - taken branches resolved in X;
  - multi-cycle mul/div operations in X.
- Issues stalls, bubbles and flushes for these conditions.
- Runs a small FSM that sequences the multdiv unit handshake.

Parameters:
- OP_W, 5, width of opcode/register/aluop fields
- CNT_W, 16, width of stall counter (optional feature only)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- dOpcode  in  5  opcode of instruction in decode
- dRs  in  5  decode source register A
- dRt  in  5  decode source register B
- dUsesRt  in  1  decode instruction reads dRt
- xOpcode  in  5  opcodeOut of D/X latch
- xAluop  in  5  aluopOut of D/X latch
- xRd  in  5  rdOut of D/X latch
- xBranchTaken  in  1  branch/jump in X redirects PC this cycle
- mdReady  in  1  multdiv result valid (single-cycle pulse)
- pcEnable  out  1  PC register write enable
- fdEnable  out  1  F/D latch enable
- dxEnable  out  1  D/X latch enable
- xmEnable  out  1  X/M latch enable
- dxNop  out  1  selects all-zero (nop) into D/X latch inputs
- flush  out  1  registered pulse to F/D and D/X latch reset pins
- mdStart  out  1  registered one-cycle start to multdiv
- mdBusy  out  1  high while FSM is in MD_WAIT

Behaviour:
- Constants (package):
  - RTYPE = 00000
  - LW = 01000
  - ALU_MUL = 00110
  - ALU_DIV = 00111
- isMD = (xOpcode == RTYPE) && (xAluop == ALU_MUL || xAluop == ALU_DIV).
- Load-use: loadUse = (xOpcode == LW) && (xRd != 0) && ((xRd == dRs) || (dUsesRt && xRd == dRt)).
- FSM states: RUN, MD_WAIT, MD_DONE. Reset state is RUN.
- RUN:
  - If isMD: next state MD_WAIT; mdStart registered high for exactly the next cycle.
  - Otherwise stay in RUN.
- MD_WAIT:
  - Stay until mdReady = 1, then go to MD_DONE.
  - mdReady in the same cycle the FSM enters MD_WAIT is honoured.
- MD_DONE: always returns to RUN after one cycle. The instruction leaves X here, so isMD is not re-triggered.
- Enables are combinational from state and inputs:
  - isMD in RUN, or any cycle in MD_WAIT: all four enables = 0 and dxNop = 0 (full freeze).
  - MD_DONE: all enables = 1, so X/M captures the result.
  - loadUse in RUN (and not isMD): pcEnable = fdEnable = 0, dxEnable = 1, dxNop = 1, xmEnable = 1. This inserts one bubble, and the hazard clears on the next cycle.
  - Otherwise: all enables = 1 and dxNop = 0.
- Branch:
  - xBranchTaken sampled at edge n sets flush = 1 during cycle n+1 only.
  - flush is a glitch-free flop output, because the latch reset pins are asynchronous.
  - In the cycle xBranchTaken = 1, loadUse is ignored: dxNop = 0 and enables = 1.
  - isMD and xBranchTaken are mutually exclusive by ISA; if both occur, isMD wins and flush is suppressed.
- Flush occurring during a freeze (MD_WAIT) is impossible, since xBranchTaken is only accepted in RUN.
- Reset: asynchronous; forces state = RUN, flush = 0, mdStart = 0 immediately. Combinational enables then evaluate as in RUN.
- Reset mid-MD_WAIT returns the FSM to RUN. A later mdReady in RUN is ignored.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined:
  - Adds outputs stallCycles[CNT_W-1:0] and bubbleCount[CNT_W-1:0].
  - stallCycles increments each cycle that pcEnable = 0.
  - bubbleCount increments each cycle dxNop = 1 or flush = 1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: counters and ports are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - the RTYPE, LW, ALU_MUL and ALU_DIV constants;
  - the FSM state enum, 2 bits: RUN = 0, MD_WAIT = 1, MD_DONE = 2.
- One sub-module: md_seq (the FSM plus the mdStart/mdBusy logic).
- Load-use compare and enable muxing stay in the top level.

Test Plan:
- Load-use:
  - Stimulus: xOpcode = 01000, xRd = 3, dRs = 3 for one cycle.
  - Response: pcEnable = fdEnable = 0, dxNop = 1 that cycle; all enables = 1 and dxNop = 0 the next cycle.
- Register-zero case:
  - Stimulus: xRd = 0 = dRs with LW.
  - Response: no stall.
- dUsesRt qualification:
  - Stimulus: xRd = 5 = dRt, first with dUsesRt = 0, then with dUsesRt = 1.
  - Response: stall only when dUsesRt = 1.
- Branch:
  - Stimulus: xBranchTaken = 1 at edge 10, with a simultaneous loadUse.
  - Response: flush = 1 during cycle 11 only; dxNop = 0 in cycle 10.
- Multiply:
  - Stimulus: xAluop = 00110, with mdReady asserted 5 cycles after mdStart.
  - Response:
    - mdStart is high for exactly one cycle;
    - all enables are low from isMD detection until mdReady;
    - one MD_DONE cycle follows with enables = 1;
    - the FSM then returns to RUN, with no second mdStart.
- Async reset in MD_WAIT:
  - Stimulus: assert reset mid-cycle, deassert, then pulse mdReady.
  - Response: mdBusy = 0 immediately, state = RUN, mdReady ignored.
- Optional feature, with HAZARD_STALL_CNT_EN defined:
  - Stimulus: the multiply scenario above with a 5-cycle wait.
  - Response: stallCycles = 6 (1 RUN-detect cycle plus 5 MD_WAIT cycles).
  - Stimulus: force 2^16 stall cycles.
  - Response: stallCycles holds at 16'hFFFF.
